// File: rtl/onehot_mux_pipe_pkg.sv
// Shared types and helpers for the one-hot select mux pipeline.
package mux_pkg;

  // Occupancy of the two-entry output buffer.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b10
  } buf_state_e;

  // Handling of beats whose select is not exactly one-hot.
  localparam int ILLEGAL_DROP = 0;
  localparam int ILLEGAL_FWD  = 1;

  // Widest select vector the helpers below accept (callers zero-extend).
  localparam int SEL_MAX_WIDTH = 64;

  // Number of set bits in a select vector.
  function automatic int unsigned popcount(input logic [SEL_MAX_WIDTH-1:0] v);
    int unsigned cnt;
    cnt = 32'd0;
    for (int i = 0; i < SEL_MAX_WIDTH; i++) begin
      cnt = cnt + {31'd0, v[i]};
    end
    return cnt;
  endfunction

  // A select is legal only when exactly one bit is set.
  function automatic logic is_onehot(input logic [SEL_MAX_WIDTH-1:0] v);
    return (popcount(v) == 32'd1);
  endfunction

endpackage

// File: rtl/onehot_mux_pipe_if.sv
// Input and output stream signals of the one-hot mux pipeline.
interface onehot_mux_pipe_if #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_INPUTS = 4
);
  logic [NUM_INPUTS*DATA_WIDTH-1:0] in_data;
  logic [NUM_INPUTS-1:0]            in_sel;
  logic                             in_valid;
  logic                             in_ready;
  logic [DATA_WIDTH-1:0]            out_data;
  logic                             out_err;
  logic                             out_valid;
  logic                             out_ready;

  // Producer/consumer side.
  modport master (
    output in_data, in_sel, in_valid, out_ready,
    input  in_ready, out_data, out_err, out_valid
  );

  // Mux side.
  modport slave (
    input  in_data, in_sel, in_valid, out_ready,
    output in_ready, out_data, out_err, out_valid
  );
endinterface

// File: rtl/onehot_mux_pipe_skid_buffer.sv
// Two-entry skid buffer: main register drives the outputs, skid register
// absorbs the one beat that can arrive after the consumer stalls.
module skid_buffer
  import mux_pkg::*;
#(
  parameter int WIDTH = 33
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  buf_state_e       state_r;
  buf_state_e       state_nxt_s;
  logic [WIDTH-1:0] main_r;
  logic [WIDTH-1:0] skid_r;
  logic             out_valid_r;
  logic             in_ready_r;
  logic             accept_s;
  logic             xfer_s;
  logic             load_main_in_s;
  logic             load_main_skid_s;
  logic             load_skid_s;

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_data  = main_r;

  // Next occupancy and which register each beat lands in.
  always_comb begin
    state_nxt_s      = state_r;
    load_main_in_s   = 1'b0;
    load_main_skid_s = 1'b0;
    load_skid_s      = 1'b0;
    accept_s         = in_valid & in_ready_r;
    xfer_s           = out_valid_r & out_ready;
    case (state_r)
      EMPTY: begin
        if (accept_s) begin
          state_nxt_s    = ONE;
          load_main_in_s = 1'b1;
        end else begin
          state_nxt_s = EMPTY;
        end
      end
      ONE: begin
        if (accept_s && xfer_s) begin
          state_nxt_s    = ONE;
          load_main_in_s = 1'b1;
        end else if (accept_s) begin
          state_nxt_s = FULL;
          load_skid_s = 1'b1;
        end else if (xfer_s) begin
          state_nxt_s = EMPTY;
        end else begin
          state_nxt_s = ONE;
        end
      end
      FULL: begin
        if (xfer_s) begin
          state_nxt_s      = ONE;
          load_main_skid_s = 1'b1;
        end else begin
          state_nxt_s = FULL;
        end
      end
      default: begin
        state_nxt_s = EMPTY;
      end
    endcase
  end

  // State, data registers and the registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= EMPTY;
      main_r      <= '0;
      skid_r      <= '0;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      out_valid_r <= (state_nxt_s != EMPTY);
      in_ready_r  <= (state_nxt_s != FULL);
      if (load_main_in_s) begin
        main_r <= in_data;
      end else if (load_main_skid_s) begin
        main_r <= skid_r;
      end else begin
        main_r <= main_r;
      end
      if (load_skid_s) begin
        skid_r <= in_data;
      end else begin
        skid_r <= skid_r;
      end
    end
  end

endmodule

// File: rtl/onehot_mux_pipe.sv
// N-input one-hot select mux with illegal-select detection, saturating
// error counter and a registered valid/ready output stage.
module onehot_mux_pipe
  import mux_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int NUM_INPUTS    = 4,
  parameter int ERR_CNT_WIDTH = 8,
  parameter int ILLEGAL_MODE  = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  onehot_mux_pipe_if.slave         bus,
  input  logic                     err_clr,
  output logic [ERR_CNT_WIDTH-1:0] err_count,
  output logic                     err_sticky
);

  localparam logic [ERR_CNT_WIDTH-1:0] ERR_CNT_MAX = '1;

  logic [SEL_MAX_WIDTH-1:0]  sel_ext_s;
  logic                      legal_s;
  logic [DATA_WIDTH-1:0]     data_s;
  logic [DATA_WIDTH:0]       enq_beat_s;
  logic                      enq_valid_s;
  logic                      buf_ready_s;
  logic [DATA_WIDTH:0]       out_beat_s;
  logic                      illegal_acc_s;
  logic [ERR_CNT_WIDTH-1:0]  err_count_r;
  logic                      err_sticky_r;

  // Decode the select and build the beat that enters the buffer.
  always_comb begin
    sel_ext_s                 = '0;
    sel_ext_s[NUM_INPUTS-1:0] = bus.in_sel;
    legal_s                   = is_onehot(sel_ext_s);
    data_s                    = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (bus.in_sel[i]) begin
        data_s = data_s | bus.in_data[i*DATA_WIDTH +: DATA_WIDTH];
      end else begin
        data_s = data_s;
      end
    end
    if (legal_s) begin
      enq_beat_s  = {1'b0, data_s};
      enq_valid_s = bus.in_valid;
    end else begin
      // Illegal beats carry zero data and the error tag; dropped in mode 0.
      enq_beat_s  = {1'b1, {DATA_WIDTH{1'b0}}};
      enq_valid_s = bus.in_valid & (ILLEGAL_MODE == ILLEGAL_FWD);
    end
    illegal_acc_s = bus.in_valid & buf_ready_s & ~legal_s;
  end

  skid_buffer #(
    .WIDTH (DATA_WIDTH + 1)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_data   (enq_beat_s),
    .in_valid  (enq_valid_s),
    .in_ready  (buf_ready_s),
    .out_data  (out_beat_s),
    .out_valid (bus.out_valid),
    .out_ready (bus.out_ready)
  );

  assign bus.in_ready = buf_ready_s;
  assign bus.out_data = out_beat_s[DATA_WIDTH-1:0];
  assign bus.out_err  = out_beat_s[DATA_WIDTH];
  assign err_count    = err_count_r;
  assign err_sticky   = err_sticky_r;

  // Error counter and sticky flag; a clear in the same cycle as an illegal
  // accept clears first and then counts that beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_count_r  <= '0;
      err_sticky_r <= 1'b0;
    end else if (illegal_acc_s) begin
      if (err_clr) begin
        err_count_r <= ERR_CNT_WIDTH'(1);
      end else if (err_count_r == ERR_CNT_MAX) begin
        err_count_r <= err_count_r;
      end else begin
        err_count_r <= err_count_r + ERR_CNT_WIDTH'(1);
      end
      err_sticky_r <= 1'b1;
    end else if (err_clr) begin
      err_count_r  <= '0;
      err_sticky_r <= 1'b0;
    end else begin
      err_count_r  <= err_count_r;
      err_sticky_r <= err_sticky_r;
    end
  end

endmodule

// File: tb/tb_onehot_mux_pipe.sv
// Bench for onehot_mux_pipe: dut_a drops illegal beats (2-bit counter),
// dut_b forwards them tagged (8-bit counter); both see the same stimulus.
module tb_onehot_mux_pipe;
  localparam int DW = 32;
  localparam int NI = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NI*DW-1:0]  in_data_v = '0;
  logic [NI-1:0]     in_sel = '0;
  logic              in_valid = 1'b0;
  logic              out_ready = 1'b0;
  logic              err_clr = 1'b0;
  logic [1:0]        err_count_a;
  logic              err_sticky_a;
  logic [7:0]        err_count_b;
  logic              err_sticky_b;

  int total = 0;
  int bad   = 0;

  onehot_mux_pipe_if #(.DATA_WIDTH(DW), .NUM_INPUTS(NI)) bus_a ();
  onehot_mux_pipe_if #(.DATA_WIDTH(DW), .NUM_INPUTS(NI)) bus_b ();

  assign bus_a.in_data   = in_data_v;
  assign bus_a.in_sel    = in_sel;
  assign bus_a.in_valid  = in_valid;
  assign bus_a.out_ready = out_ready;
  assign bus_b.in_data   = in_data_v;
  assign bus_b.in_sel    = in_sel;
  assign bus_b.in_valid  = in_valid;
  assign bus_b.out_ready = out_ready;

  onehot_mux_pipe #(.DATA_WIDTH(DW), .NUM_INPUTS(NI), .ERR_CNT_WIDTH(2), .ILLEGAL_MODE(0)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a), .err_clr(err_clr),
    .err_count(err_count_a), .err_sticky(err_sticky_a));

  onehot_mux_pipe #(.DATA_WIDTH(DW), .NUM_INPUTS(NI), .ERR_CNT_WIDTH(8), .ILLEGAL_MODE(1)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b), .err_clr(err_clr),
    .err_count(err_count_b), .err_sticky(err_sticky_b));

  always #5 clk = ~clk;

  // Reference model: a capacity-2 FIFO of {err,data} beats per DUT.
  logic [DW:0] mfifo [2][2];
  int          mocc [2];
  logic        mready [2];
  int          mcnt [2];
  logic        msticky [2];
  int          mmax [2];
  int          mmode [2];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input int m);
    logic        legal;
    logic [DW:0] beat;
    logic        xfer;
    logic        acc;
    int          base;
    if (rst) begin
      mocc[m] = 0; mready[m] = 1'b0; mcnt[m] = 0; msticky[m] = 1'b0;
    end else begin
      xfer  = (mocc[m] > 0) && out_ready;
      acc   = in_valid && mready[m];
      legal = ($countones(in_sel) == 1);
      beat  = {1'b1, {DW{1'b0}}};
      for (int i = 0; i < NI; i++)
        if (legal && in_sel[i]) beat = {1'b0, in_data_v[i*DW +: DW]};
      if (xfer) begin
        mfifo[m][0] = mfifo[m][1];
        mocc[m]--;
      end
      if (acc && (legal || mmode[m] == 1) && mocc[m] < 2) begin
        mfifo[m][mocc[m]] = beat;
        mocc[m]++;
      end
      if (acc && !legal) begin
        base = err_clr ? 0 : mcnt[m];
        mcnt[m] = (base + 1 > mmax[m]) ? mmax[m] : base + 1;
        msticky[m] = 1'b1;
      end else if (err_clr) begin
        mcnt[m] = 0; msticky[m] = 1'b0;
      end
      mready[m] = (mocc[m] < 2);
    end
  endtask

  task automatic check_model(input int m, input logic ov, input logic [DW-1:0] od,
                             input logic oe, input logic ir, input logic [7:0] ec,
                             input logic es);
    string p;
    p = (m == 0) ? "a" : "b";
    chk({p, ".out_valid"}, 64'(ov), 64'(mocc[m] > 0));
    if (mocc[m] > 0) begin
      chk({p, ".out_data"}, 64'(od), 64'(mfifo[m][0][DW-1:0]));
      chk({p, ".out_err"}, 64'(oe), 64'(mfifo[m][0][DW]));
    end
    chk({p, ".in_ready"}, 64'(ir), 64'(mready[m]));
    chk({p, ".err_count"}, 64'(ec), 64'(mcnt[m]));
    chk({p, ".err_sticky"}, 64'(es), 64'(msticky[m]));
  endtask

  // One clock: advance model on the edge's inputs, then compare after it.
  task automatic cycle();
    model_step(0);
    model_step(1);
    @(posedge clk);
    #1;
    check_model(0, bus_a.out_valid, bus_a.out_data, bus_a.out_err, bus_a.in_ready,
                {6'd0, err_count_a}, err_sticky_a);
    check_model(1, bus_b.out_valid, bus_b.out_data, bus_b.out_err, bus_b.in_ready,
                err_count_b, err_sticky_b);
  endtask

  typedef struct {
    logic [3:0]    sel;
    logic          vld;
    logic          ordy;
    logic          exp_ov;
    logic [DW-1:0] exp_od;
    logic          exp_ir;
  } vec_t;

  vec_t tbl [13];

  initial begin
    mmax[0] = 3;   mmode[0] = 0;
    mmax[1] = 255; mmode[1] = 1;
    for (int m = 0; m < 2; m++) begin
      mocc[m] = 0; mready[m] = 1'b0; mcnt[m] = 0; msticky[m] = 1'b0;
    end

    // Streaming without stall, then a 3-cycle stall mid-stream (dut_a view).
    tbl[0]  = '{4'b0001, 1'b1, 1'b1, 1'b1, 32'hA0, 1'b1};
    tbl[1]  = '{4'b0010, 1'b1, 1'b1, 1'b1, 32'hA1, 1'b1};
    tbl[2]  = '{4'b0100, 1'b1, 1'b1, 1'b1, 32'hA2, 1'b1};
    tbl[3]  = '{4'b1000, 1'b1, 1'b1, 1'b1, 32'hA3, 1'b1};
    tbl[4]  = '{4'b0000, 1'b0, 1'b1, 1'b0, 32'h0,  1'b1};
    tbl[5]  = '{4'b0001, 1'b1, 1'b1, 1'b1, 32'hA0, 1'b1};
    tbl[6]  = '{4'b0010, 1'b1, 1'b0, 1'b1, 32'hA0, 1'b0};
    tbl[7]  = '{4'b0100, 1'b1, 1'b0, 1'b1, 32'hA0, 1'b0};
    tbl[8]  = '{4'b0100, 1'b1, 1'b0, 1'b1, 32'hA0, 1'b0};
    tbl[9]  = '{4'b0100, 1'b1, 1'b1, 1'b1, 32'hA1, 1'b1};
    tbl[10] = '{4'b0100, 1'b1, 1'b1, 1'b1, 32'hA2, 1'b1};
    tbl[11] = '{4'b1000, 1'b1, 1'b1, 1'b1, 32'hA3, 1'b1};
    tbl[12] = '{4'b0000, 1'b0, 1'b1, 1'b0, 32'h0,  1'b1};

    for (int i = 0; i < NI; i++) in_data_v[i*DW +: DW] = 32'hA0 + 32'(i);

    // Reset held for three cycles.
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("rst.out_data", 64'(bus_a.out_data), 64'h0);
      chk("rst.out_err", 64'(bus_b.out_err), 64'h0);
      chk("rst.in_ready", 64'(bus_a.in_ready), 64'h0);
    end
    rst = 1'b0;
    cycle();
    chk("post_rst.in_ready", 64'(bus_a.in_ready), 64'h1);

    // Directed table.
    for (int i = 0; i < 13; i++) begin
      in_sel = tbl[i].sel; in_valid = tbl[i].vld; out_ready = tbl[i].ordy;
      cycle();
      chk($sformatf("tbl%0d.out_valid", i), 64'(bus_a.out_valid), 64'(tbl[i].exp_ov));
      if (tbl[i].exp_ov)
        chk($sformatf("tbl%0d.out_data", i), 64'(bus_a.out_data), 64'(tbl[i].exp_od));
      chk($sformatf("tbl%0d.in_ready", i), 64'(bus_a.in_ready), 64'(tbl[i].exp_ir));
    end

    // Illegal selects: zero-hot then multi-hot.
    in_valid = 1'b1; out_ready = 1'b1; in_sel = 4'b0000;
    cycle();
    chk("ill0.a.out_valid", 64'(bus_a.out_valid), 64'h0);
    chk("ill0.b.out_valid", 64'(bus_b.out_valid), 64'h1);
    chk("ill0.b.out_err", 64'(bus_b.out_err), 64'h1);
    chk("ill0.b.out_data", 64'(bus_b.out_data), 64'h0);
    in_sel = 4'b0110;
    cycle();
    chk("ill1.a.out_valid", 64'(bus_a.out_valid), 64'h0);
    chk("ill1.b.out_err", 64'(bus_b.out_err), 64'h1);
    chk("ill1.a.err_count", 64'(err_count_a), 64'h2);
    chk("ill1.a.err_sticky", 64'(err_sticky_a), 64'h1);
    in_sel = 4'b1111; cycle();
    in_sel = 4'b0000; cycle();
    in_sel = 4'b0011; cycle();
    chk("sat.a.err_count", 64'(err_count_a), 64'h3);
    chk("sat.b.err_count", 64'(err_count_b), 64'h5);
    err_clr = 1'b1; in_sel = 4'b0000;
    cycle();
    chk("clr_ill.a.err_count", 64'(err_count_a), 64'h1);
    chk("clr_ill.a.err_sticky", 64'(err_sticky_a), 64'h1);
    chk("clr_ill.b.err_count", 64'(err_count_b), 64'h1);
    in_valid = 1'b0;
    cycle();
    chk("clr.a.err_count", 64'(err_count_a), 64'h0);
    chk("clr.a.err_sticky", 64'(err_sticky_a), 64'h0);
    err_clr = 1'b0;
    cycle();

    // Fill the buffer, then reset mid-operation.
    out_ready = 1'b0; in_valid = 1'b1; in_sel = 4'b0001; cycle();
    in_sel = 4'b0010; cycle();
    chk("full.a.in_ready", 64'(bus_a.in_ready), 64'h0);
    rst = 1'b1; in_valid = 1'b0;
    cycle();
    chk("midrst.a.out_valid", 64'(bus_a.out_valid), 64'h0);
    chk("midrst.b.out_valid", 64'(bus_b.out_valid), 64'h0);
    rst = 1'b0; out_ready = 1'b1;
    cycle();
    in_valid = 1'b1; in_sel = 4'b0100;
    cycle();
    chk("postrst.a.out_valid", 64'(bus_a.out_valid), 64'h1);
    chk("postrst.a.out_data", 64'(bus_a.out_data), 64'hA2);
    in_valid = 1'b0;
    cycle();

    // Randomized traffic against the model.
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < NI; i++) in_data_v[i*DW +: DW] = $urandom;
      if ($urandom_range(0, 9) < 8) in_sel = 4'(4'b0001 << $urandom_range(0, 3));
      else in_sel = 4'($urandom_range(0, 15));
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      err_clr   = ($urandom_range(0, 19) == 0);
      rst       = ($urandom_range(0, 99) == 0);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
